// File: rtl/qact_sched_pkg.sv
// -----------------------------------------------------------------------------
// qact_pkg
// Shared declarations for the qact_sched quantized-activation scheduler:
//   - state_t       : scheduler FSM states (IDLE, LOCK)
//   - SAT_CNT_W     : width of the saturated-beat counter
//   - calc_sh/half  : elaboration-time helpers deriving the rounding shift
//                     SH = XBF - YBF and the round-half-up offset HALF
// -----------------------------------------------------------------------------
package qact_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int SAT_CNT_W = 32;

  // Number of fractional bits dropped by the requantization shift.
  function automatic int calc_sh(input int xbf, input int ybf);
    return xbf - ybf;
  endfunction

  // Half an output LSB, expressed in input LSBs; zero for a degenerate shift
  // so an illegal configuration still elaborates far enough to report itself.
  function automatic int calc_half(input int sh);
    return (sh > 0) ? (1 << (sh - 1)) : 0;
  endfunction

endpackage

// File: rtl/qact_rr_arb.sv
// -----------------------------------------------------------------------------
// qact_rr_arb
// Combinational cyclic priority pick: returns the first requester at or after
// i_ptr (wrapping modulo R) whose request is high.
// Ports:
//   i_req   [R]   request vector
//   i_ptr   [RW]  highest-priority index for this pick
//   o_idx   [RW]  selected index (0 when nothing is requested)
//   o_found       at least one request is high
// -----------------------------------------------------------------------------
module qact_rr_arb #(
  parameter int R  = 4,
  parameter int RW = $clog2(R)
) (
  input  logic [R-1:0]  i_req,
  input  logic [RW-1:0] i_ptr,
  output logic [RW-1:0] o_idx,
  output logic          o_found
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins, which avoids a loop exit.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path through the block leaves a value held and no latch is inferred.
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      if (i_req[RW'((int'(i_ptr) + k) % R)]) begin
        o_idx   = RW'((int'(i_ptr) + k) % R);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qact_sched.sv
// -----------------------------------------------------------------------------
// qact_sched
// Round-robin scheduler sharing one two-stage quantized-activation datapath
// (ReLU clip, round-half-up, right shift, saturate) among R packet requesters.
// The datapath is locked to one requester for a whole packet; results carry
// the requester index.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready [R] per-requester beat handshake
//   s_data  [R*N*XB]    per-requester beat, N signed XB-bit lanes
//   s_last  [R]         last beat of a packet
//   m_valid/m_ready     result handshake
//   m_data  [N*YB]      quantized unsigned lanes
//   m_id    [RW]        requester index of the beat
//   m_last              last beat of packet
//   busy                FSM locked or any pipeline stage valid
//   sat_clr, sat_cnt    saturated-beat counter clear / value
//                       (only when QACT_SCHED_SAT_CNT_EN is defined)
//
// Build option: define QACT_SCHED_SAT_CNT_EN to add the saturation counter.
// -----------------------------------------------------------------------------
module qact_sched
  import qact_pkg::*;
#(
  parameter int R   = 4,
  parameter int N   = 4,
  parameter int XB  = 16,
  parameter int XBF = 8,
  parameter int YB  = 8,
  parameter int YBI = 4,
  parameter int RW  = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         s_valid,
  output logic [R-1:0]         s_ready,
  input  logic [R*N*XB-1:0]    s_data,
  input  logic [R-1:0]         s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N*YB-1:0]      m_data,
  output logic [RW-1:0]        m_id,
  output logic                 m_last,
  output logic                 busy
`ifdef QACT_SCHED_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

  localparam int YBF  = YB - YBI;
  localparam int SH   = calc_sh(XBF, YBF);
  localparam int HALF = calc_half(SH);
  localparam logic [XB:0] HALF_W = (XB + 1)'(HALF);

  if (XBF <= YBF) begin : g_bad_frac
    $error("qact_sched: XBF must exceed YB-YBI");
  end
  if (R < 2) begin : g_bad_r
    $error("qact_sched: R must be at least 2");
  end

  // ---------------------------------------------------------------- control
  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_grant, w_grant_nxt;
  logic [RW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [RW-1:0]   w_pick;
  logic            w_found;
  logic            w_en;
  logic            w_accept;

  // ---------------------------------------------------------------- datapath
  logic [N*XB-1:0]      w_beat;
  logic [N-1:0][XB-1:0] w_c;
  logic [N-1:0][XB:0]   w_r;
  logic [N-1:0][XB:0]   w_q;
  logic [N-1:0][YB-1:0] w_y;
  logic [N-1:0]         w_sat;

  logic                 r_s1_valid;
  logic [N-1:0][XB:0]   r_s1_r;
  logic [RW-1:0]        r_s1_id;
  logic                 r_s1_last;

  logic                 r_s2_valid;
  logic [N-1:0][YB-1:0] r_m_data;
  logic [RW-1:0]        r_m_id;
  logic                 r_m_last;

  // The whole pipeline advances together whenever the output slot is free.
  assign w_en = !r_s2_valid || m_ready;

  qact_rr_arb #(
    .R  (R),
    .RW (RW)
  ) u_arb (
    .i_req   (s_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain stages in one edge.
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    s_ready      = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        // Arbitration cycle: nothing is accepted while the grant is chosen.
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        for (int k = 0; k < R; k++) begin
          if (r_grant == RW'(k)) s_ready[k] = w_en;
        end
        w_accept = s_valid[r_grant] && w_en;
        if (w_accept && s_last[r_grant]) begin
          w_rr_ptr_nxt = (r_grant == RW'(R - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Granted requester's beat.
  always_comb begin
    w_beat = '0;
    for (int k = 0; k < R; k++) begin
      if (r_grant == RW'(k)) w_beat = s_data[k*N*XB +: N*XB];
    end
  end

  // Stage 1 input: clip negatives, add half an output LSB in XB+1 bits.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      w_c[l] = w_beat[l*XB + XB - 1] ? '0 : w_beat[l*XB +: XB];
      w_r[l] = {1'b0, w_c[l]} + HALF_W;
    end
  end

  // Stage 2 input: drop SH fractional bits, saturate to the unsigned range.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      w_q[l]   = r_s1_r[l] >> SH;
      w_sat[l] = |w_q[l][XB:YB];
      w_y[l]   = w_sat[l] ? '1 : w_q[l][YB-1:0];
    end
  end

`ifdef QACT_SCHED_SAT_CNT_EN
  logic                 r_m_sat;
  logic [SAT_CNT_W-1:0] r_sat_cnt;
`endif

  // Payload registers load only with a valid beat, so m_* keep the last
  // delivered result rather than tracking idle input data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_id    <= '0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_m_data   <= '0;
      r_m_id     <= '0;
      r_m_last   <= 1'b0;
`ifdef QACT_SCHED_SAT_CNT_EN
      r_m_sat    <= 1'b0;
`endif
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (w_accept) begin
        r_s1_r    <= w_r;
        r_s1_id   <= r_grant;
        r_s1_last <= s_last[r_grant];
      end
      if (r_s1_valid) begin
        r_m_data <= w_y;
        r_m_id   <= r_s1_id;
        r_m_last <= r_s1_last;
`ifdef QACT_SCHED_SAT_CNT_EN
        r_m_sat  <= |w_sat;
`endif
      end
    end
  end

`ifdef QACT_SCHED_SAT_CNT_EN
  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid && m_ready && r_m_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

  assign m_valid = r_s2_valid;
  assign m_data  = r_m_data;
  assign m_id    = r_m_id;
  assign m_last  = r_m_last;
  assign busy    = (r_state == LOCK) || r_s1_valid || r_s2_valid;

endmodule
